// File: rtl/multi_obstacle_control.sv
// Obstacle engine: NUM_OBS independent falling obstacle slots with LFSR-placed spawns,
// a speed ramp driven by retirements and a saturating score.
module multi_obstacle_control #(
  parameter int          NUM_OBS        = 4,
  parameter logic [9:0]  OBS_W          = 10'd30,
  parameter logic [9:0]  OBS_H          = 10'd30,
  parameter logic [9:0]  SCREEN_W       = 10'd640,
  parameter logic [9:0]  SCREEN_H       = 10'd480,
  parameter logic [3:0]  INIT_SPEED     = 4'd4,
  parameter logic [3:0]  MAX_SPEED      = 4'd12,
  parameter int          SPEED_STEP     = 5,
  parameter int          SPAWN_INTERVAL = 40,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    game_en,
  input  logic                    collision,
  output logic [10*NUM_OBS-1:0]   obs_x_bus,
  output logic [10*NUM_OBS-1:0]   obs_y_bus,
  output logic [NUM_OBS-1:0]      obs_active,
  output logic [3:0]              speed,
  output logic [15:0]             score,
  output logic [9:0]              obstacle_width,
  output logic [9:0]              obstacle_height
);

  localparam logic [9:0] RETIRE_Y = SCREEN_H - OBS_H;
  localparam logic [9:0] X_RANGE  = SCREEN_W - OBS_W;
  localparam int TW = (SPAWN_INTERVAL > 1) ? $clog2(SPAWN_INTERVAL) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(SPAWN_INTERVAL - 1);
  localparam int CW = $clog2(NUM_OBS + 1);
  localparam int SW = $clog2(SPEED_STEP + NUM_OBS + 1);
  localparam logic [SW-1:0] STEP_N = SW'(SPEED_STEP);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } slot_state_t;

  slot_state_t     state_r [NUM_OBS];
  slot_state_t     state_s [NUM_OBS];
  logic [9:0]      x_r     [NUM_OBS];
  logic [9:0]      x_s     [NUM_OBS];
  logic [9:0]      y_r     [NUM_OBS];
  logic [9:0]      y_s     [NUM_OBS];
  logic [TW-1:0]   timer_r, timer_s;
  logic [15:0]     lfsr_r, lfsr_s;
  logic [3:0]      speed_r, speed_s;
  logic [15:0]     score_r, score_s;
  logic [SW-1:0]   step_r, step_s;
  logic [CW-1:0]   retire_cnt_s;
  logic [16:0]     score_sum_s;
  logic [SW-1:0]   step_sum_s;
  logic            tick_s;
  logic            idle_found_s;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Fold the raw 10-bit random value into [0, X_RANGE) so obstacles stay on screen.
  function automatic logic [9:0] map_x(input logic [9:0] r);
    return (r >= X_RANGE) ? (r - X_RANGE) : r;
  endfunction

  // Next-state logic for slots, spawn timer, LFSR, score and speed ramp.
  always_comb begin
    state_s      = state_r;
    x_s          = x_r;
    y_s          = y_r;
    timer_s      = timer_r;
    lfsr_s       = lfsr_r;
    speed_s      = speed_r;
    score_s      = score_r;
    step_s       = step_r;
    retire_cnt_s = '0;
    score_sum_s  = '0;
    step_sum_s   = '0;
    idle_found_s = 1'b0;
    tick_s       = game_en & ~collision;

    if (tick_s) begin
      for (int i = 0; i < NUM_OBS; i++) begin
        if (state_r[i] == ACTIVE) begin
          if (y_r[i] >= RETIRE_Y) begin
            state_s[i]   = IDLE;
            y_s[i]       = 10'd0;
            retire_cnt_s = retire_cnt_s + CW'(1);
          end else begin
            y_s[i] = y_r[i] + {6'd0, speed_r};
          end
        end else begin
          y_s[i] = y_r[i];
        end
      end

      // Eligibility uses the state at the start of the tick, so a slot retiring now waits a tick.
      for (int i = 0; i < NUM_OBS; i++) begin
        if ((state_r[i] == IDLE) && !idle_found_s) begin
          idle_found_s = 1'b1;
          if (timer_r == TIMER_LAST) begin
            state_s[i] = ACTIVE;
            y_s[i]     = 10'd0;
            x_s[i]     = map_x(lfsr_r[9:0]);
          end else begin
            state_s[i] = IDLE;
          end
        end else begin
          idle_found_s = idle_found_s;
        end
      end

      if (timer_r == TIMER_LAST) begin
        if (idle_found_s) begin
          timer_s = '0;
          lfsr_s  = lfsr_next(lfsr_r);
        end else begin
          timer_s = timer_r;
        end
      end else begin
        timer_s = timer_r + TW'(1);
      end

      score_sum_s = {1'b0, score_r} + 17'(retire_cnt_s);
      if (score_sum_s[16]) begin
        score_s = 16'hFFFF;
      end else begin
        score_s = score_sum_s[15:0];
      end

      step_sum_s = step_r + SW'(retire_cnt_s);
      if (step_sum_s >= STEP_N) begin
        step_s = step_sum_s - STEP_N;
        if (speed_r < MAX_SPEED) begin
          speed_s = speed_r + 4'd1;
        end else begin
          speed_s = MAX_SPEED;
        end
      end else begin
        step_s = step_sum_s;
      end
    end else begin
      timer_s = timer_r;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_OBS; i++) begin
        state_r[i] <= IDLE;
        x_r[i]     <= 10'd0;
        y_r[i]     <= 10'd0;
      end
      timer_r <= '0;
      lfsr_r  <= LFSR_SEED;
      speed_r <= INIT_SPEED;
      score_r <= 16'd0;
      step_r  <= '0;
    end else begin
      for (int i = 0; i < NUM_OBS; i++) begin
        state_r[i] <= state_s[i];
        x_r[i]     <= x_s[i];
        y_r[i]     <= y_s[i];
      end
      timer_r <= timer_s;
      lfsr_r  <= lfsr_s;
      speed_r <= speed_s;
      score_r <= score_s;
      step_r  <= step_s;
    end
  end

  for (genvar g = 0; g < NUM_OBS; g++) begin : g_out
    assign obs_x_bus[10*g +: 10] = x_r[g];
    assign obs_y_bus[10*g +: 10] = y_r[g];
    assign obs_active[g]         = (state_r[g] == ACTIVE);
  end

  assign speed           = speed_r;
  assign score           = score_r;
  assign obstacle_width  = OBS_W;
  assign obstacle_height = OBS_H;

endmodule

// File: tb/tb_multi_obstacle_control.sv
// Directed bench for multi_obstacle_control: a default-parameter instance, a fast-spawn
// instance and a tiny-screen instance that reaches speed and score saturation quickly.
module tb_multi_obstacle_control;

  logic clk = 1'b0;
  logic rst_main = 1'b1, rst_aux = 1'b1;
  logic en_main = 1'b0, en_fast = 1'b0, en_sat = 1'b0;
  logic col_main = 1'b0, col_fast = 1'b0, col_sat = 1'b0;

  logic [39:0] m_x_bus, m_y_bus, f_x_bus, f_y_bus;
  logic [19:0] s_x_bus, s_y_bus;
  logic [3:0]  m_active, f_active;
  logic [1:0]  s_active;
  logic [3:0]  m_speed, f_speed, s_speed;
  logic [15:0] m_score, f_score, s_score;
  logic [9:0]  m_w, m_h, f_w, f_h, s_w, s_h;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  multi_obstacle_control u_main (
    .clk(clk), .rst(rst_main), .game_en(en_main), .collision(col_main),
    .obs_x_bus(m_x_bus), .obs_y_bus(m_y_bus), .obs_active(m_active),
    .speed(m_speed), .score(m_score), .obstacle_width(m_w), .obstacle_height(m_h)
  );

  multi_obstacle_control #(.SPAWN_INTERVAL(1)) u_fast (
    .clk(clk), .rst(rst_aux), .game_en(en_fast), .collision(col_fast),
    .obs_x_bus(f_x_bus), .obs_y_bus(f_y_bus), .obs_active(f_active),
    .speed(f_speed), .score(f_score), .obstacle_width(f_w), .obstacle_height(f_h)
  );

  multi_obstacle_control #(.NUM_OBS(2), .SCREEN_H(10'd30), .SPAWN_INTERVAL(1)) u_sat (
    .clk(clk), .rst(rst_aux), .game_en(en_sat), .collision(col_sat),
    .obs_x_bus(s_x_bus), .obs_y_bus(s_y_bus), .obs_active(s_active),
    .speed(s_speed), .score(s_score), .obstacle_width(s_w), .obstacle_height(s_h)
  );

  task automatic tick_main(input int n);
    repeat (n) begin en_main = 1'b1; @(posedge clk); #1; en_main = 1'b0; end
  endtask

  task automatic tick_fast(input int n);
    repeat (n) begin en_fast = 1'b1; @(posedge clk); #1; en_fast = 1'b0; end
  endtask

  task automatic test_reset;
    rst_main = 1'b0; rst_aux = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst_main = 1'b1; rst_aux = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (m_active !== 4'b0000) begin n_bad++; $display("FAIL reset_active: got %b want 0000", m_active); end
    n_cmp++; if (m_speed !== 4'd4) begin n_bad++; $display("FAIL reset_speed: got %0d want 4", m_speed); end
    n_cmp++; if (m_score !== 16'd0) begin n_bad++; $display("FAIL reset_score: got %0d want 0", m_score); end
    n_cmp++; if (m_w !== 10'd30) begin n_bad++; $display("FAIL width: got %0d want 30", m_w); end
    n_cmp++; if (m_h !== 10'd30) begin n_bad++; $display("FAIL height: got %0d want 30", m_h); end
    n_cmp++; if (m_x_bus !== 40'd0 || m_y_bus !== 40'd0) begin n_bad++; $display("FAIL reset_xy: got %h/%h want 0", m_x_bus, m_y_bus); end
    n_cmp++; if (f_active !== 4'b0000 || s_active !== 2'b00) begin n_bad++; $display("FAIL reset_aux_active: got %b/%b want 0", f_active, s_active); end
  endtask

  task automatic test_spawn;
    tick_main(39);
    n_cmp++; if (m_active !== 4'b0000) begin n_bad++; $display("FAIL spawn_early: got %b want 0000", m_active); end
    tick_main(1);
    n_cmp++; if (m_active !== 4'b0001) begin n_bad++; $display("FAIL spawn0_active: got %b want 0001", m_active); end
    n_cmp++; if (m_x_bus[9:0] !== 10'd225) begin n_bad++; $display("FAIL spawn0_x: got %0d want 225", m_x_bus[9:0]); end
    n_cmp++; if (m_y_bus[9:0] !== 10'd0) begin n_bad++; $display("FAIL spawn0_y: got %0d want 0", m_y_bus[9:0]); end
    tick_main(39);
    n_cmp++; if (m_y_bus[9:0] !== 10'd156) begin n_bad++; $display("FAIL fall0_y: got %0d want 156", m_y_bus[9:0]); end
    n_cmp++; if (m_active !== 4'b0001) begin n_bad++; $display("FAIL spawn1_early: got %b want 0001", m_active); end
    tick_main(1);
    n_cmp++; if (m_active !== 4'b0011) begin n_bad++; $display("FAIL spawn1_active: got %b want 0011", m_active); end
    n_cmp++; if (m_x_bus[19:10] !== 10'd14) begin n_bad++; $display("FAIL spawn1_x: got %0d want 14", m_x_bus[19:10]); end
    n_cmp++; if (m_y_bus[19:10] !== 10'd0 || m_y_bus[9:0] !== 10'd160) begin n_bad++; $display("FAIL spawn1_y: got %0d/%0d want 0/160", m_y_bus[19:10], m_y_bus[9:0]); end
  endtask

  task automatic test_collision;
    tick_main(20);
    col_main = 1'b1;
    tick_main(20);
    n_cmp++; if (m_y_bus[9:0] !== 10'd240 || m_y_bus[19:10] !== 10'd80) begin n_bad++; $display("FAIL freeze_y: got %0d/%0d want 240/80", m_y_bus[9:0], m_y_bus[19:10]); end
    n_cmp++; if (m_score !== 16'd0 || m_active !== 4'b0011) begin n_bad++; $display("FAIL freeze_state: got score %0d active %b want 0 0011", m_score, m_active); end
    col_main = 1'b0;
    tick_main(19);
    n_cmp++; if (m_y_bus[9:0] !== 10'd316) begin n_bad++; $display("FAIL resume_y: got %0d want 316", m_y_bus[9:0]); end
    n_cmp++; if (m_active !== 4'b0011) begin n_bad++; $display("FAIL timer_held: got %b want 0011", m_active); end
    tick_main(1);
    n_cmp++; if (m_active !== 4'b0111) begin n_bad++; $display("FAIL spawn2_active: got %b want 0111", m_active); end
    n_cmp++; if (m_x_bus[29:20] !== 10'd312) begin n_bad++; $display("FAIL spawn2_x: got %0d want 312", m_x_bus[29:20]); end
  endtask

  task automatic test_retire;
    tick_main(33);
    n_cmp++; if (m_y_bus[9:0] !== 10'd452 || m_active[0] !== 1'b1) begin n_bad++; $display("FAIL pre_retire: got y %0d act %b want 452 1", m_y_bus[9:0], m_active[0]); end
    n_cmp++; if (m_score !== 16'd0) begin n_bad++; $display("FAIL pre_retire_score: got %0d want 0", m_score); end
    tick_main(1);
    n_cmp++; if (m_active !== 4'b0110) begin n_bad++; $display("FAIL retire_active: got %b want 0110", m_active); end
    n_cmp++; if (m_y_bus[9:0] !== 10'd0) begin n_bad++; $display("FAIL retire_y: got %0d want 0", m_y_bus[9:0]); end
    n_cmp++; if (m_score !== 16'd1 || m_speed !== 4'd4) begin n_bad++; $display("FAIL retire_score: got %0d spd %0d want 1 4", m_score, m_speed); end
  endtask

  task automatic test_fast_spawn;
    tick_fast(1);
    n_cmp++; if (f_active !== 4'b0001) begin n_bad++; $display("FAIL fast_t1: got %b want 0001", f_active); end
    tick_fast(1);
    n_cmp++; if (f_active !== 4'b0011) begin n_bad++; $display("FAIL fast_t2: got %b want 0011", f_active); end
    tick_fast(2);
    n_cmp++; if (f_active !== 4'b1111) begin n_bad++; $display("FAIL fast_t4: got %b want 1111", f_active); end
    n_cmp++; if (f_x_bus[29:20] !== 10'd312 || f_x_bus[39:30] !== 10'd156) begin n_bad++; $display("FAIL fast_x: got %0d/%0d want 312/156", f_x_bus[29:20], f_x_bus[39:30]); end
    tick_fast(1);
    n_cmp++; if (f_y_bus[9:0] !== 10'd16 || f_y_bus[39:30] !== 10'd4) begin n_bad++; $display("FAIL fast_t5_y: got %0d/%0d want 16/4", f_y_bus[9:0], f_y_bus[39:30]); end
    tick_fast(109);
    n_cmp++; if (f_y_bus[9:0] !== 10'd452 || f_score !== 16'd0) begin n_bad++; $display("FAIL fast_t114: got y %0d score %0d want 452 0", f_y_bus[9:0], f_score); end
    tick_fast(1);
    n_cmp++; if (f_active !== 4'b1110 || f_score !== 16'd1) begin n_bad++; $display("FAIL fast_t115: got %b score %0d want 1110 1", f_active, f_score); end
    tick_fast(1);
    n_cmp++; if (f_active !== 4'b1101 || f_score !== 16'd2) begin n_bad++; $display("FAIL respawn: got %b score %0d want 1101 2", f_active, f_score); end
    n_cmp++; if (f_x_bus[9:0] !== 10'd78 || f_y_bus[9:0] !== 10'd0) begin n_bad++; $display("FAIL respawn_xy: got %0d/%0d want 78/0", f_x_bus[9:0], f_y_bus[9:0]); end
  endtask

  task automatic test_speed_ramp;
    tick_fast(113);
    n_cmp++; if (f_speed !== 4'd4 || f_score !== 16'd4) begin n_bad++; $display("FAIL ramp_pre: got spd %0d score %0d want 4 4", f_speed, f_score); end
    tick_fast(1);
    n_cmp++; if (f_speed !== 4'd5 || f_score !== 16'd5) begin n_bad++; $display("FAIL ramp_step: got spd %0d score %0d want 5 5", f_speed, f_score); end
  endtask

  task automatic test_saturation;
    en_sat = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    n_cmp++; if (s_speed !== 4'd11 || s_score !== 16'd39) begin n_bad++; $display("FAIL sat_t40: got spd %0d score %0d want 11 39", s_speed, s_score); end
    @(posedge clk); #1;
    n_cmp++; if (s_speed !== 4'd12 || s_score !== 16'd40) begin n_bad++; $display("FAIL sat_t41: got spd %0d score %0d want 12 40", s_speed, s_score); end
    repeat (65494) @(posedge clk);
    #1;
    n_cmp++; if (s_score !== 16'hFFFE) begin n_bad++; $display("FAIL score_fffe: got %h want fffe", s_score); end
    @(posedge clk); #1;
    n_cmp++; if (s_score !== 16'hFFFF) begin n_bad++; $display("FAIL score_ffff: got %h want ffff", s_score); end
    repeat (20) @(posedge clk);
    #1;
    n_cmp++; if (s_score !== 16'hFFFF || s_speed !== 4'd12) begin n_bad++; $display("FAIL sat_hold: got %h spd %0d want ffff 12", s_score, s_speed); end
    en_sat = 1'b0;
  endtask

  task automatic test_mid_reset;
    rst_main = 1'b0;
    #2;
    n_cmp++; if (m_active !== 4'b0000 || m_score !== 16'd0 || m_speed !== 4'd4) begin n_bad++; $display("FAIL midrst: got %b %0d %0d want 0000 0 4", m_active, m_score, m_speed); end
    n_cmp++; if (m_y_bus !== 40'd0 || m_x_bus !== 40'd0) begin n_bad++; $display("FAIL midrst_xy: got %h/%h want 0", m_x_bus, m_y_bus); end
    @(posedge clk); #1;
    rst_main = 1'b1;
    tick_main(40);
    n_cmp++; if (m_active !== 4'b0001 || m_x_bus[9:0] !== 10'd225) begin n_bad++; $display("FAIL midrst_respawn: got %b x %0d want 0001 225", m_active, m_x_bus[9:0]); end
  endtask

  initial begin
    test_reset;
    test_spawn;
    test_collision;
    test_retire;
    test_fast_spawn;
    test_speed_ramp;
    test_saturation;
    test_mid_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
